// File: rtl/reservation_station_if.sv
// Issue, common-data-bus and dispatch signals between a reservation station
// and its neighbours (issue stage, CDB, functional unit).
interface reservation_station_if #(
   parameter int WORD_SIZE    = 32,
   parameter int RB_SIZE      = 8,
   parameter int RB_INDEX     = 4,
   parameter int OPCODE_WIDTH = 6
);
   // Handshake: a transfer happens on the rising edge where valid and ready
   // are both 1; valid never depends combinationally on the ready it meets.
   logic                        issue_valid;
   logic                        issue_ready;
   logic [OPCODE_WIDTH-1:0]     issue_op;
   logic [RB_INDEX-1:0]         issue_dest;
   logic [WORD_SIZE-1:0]        issue_vj;
   logic [WORD_SIZE-1:0]        issue_vk;
   logic [RB_INDEX-1:0]         issue_qj;
   logic [RB_INDEX-1:0]         issue_qk;
   logic [WORD_SIZE*RB_SIZE-1:0] CDB_data_data;
   logic [RB_SIZE-1:0]          CDB_data_valid;
   logic                        disp_valid;
   logic                        disp_ready;
   logic [OPCODE_WIDTH-1:0]     disp_op;
   logic [WORD_SIZE-1:0]        disp_vj;
   logic [WORD_SIZE-1:0]        disp_vk;
   logic [RB_INDEX-1:0]         disp_dest;

   modport master (
      output issue_valid, issue_op, issue_dest, issue_vj, issue_vk, issue_qj, issue_qk,
      output CDB_data_data, CDB_data_valid, disp_ready,
      input  issue_ready, disp_valid, disp_op, disp_vj, disp_vk, disp_dest
   );

   modport slave (
      input  issue_valid, issue_op, issue_dest, issue_vj, issue_vk, issue_qj, issue_qk,
      input  CDB_data_data, CDB_data_valid, disp_ready,
      output issue_ready, disp_valid, disp_op, disp_vj, disp_vk, disp_dest
   );
endinterface

// File: rtl/reservation_station.sv
// Tomasulo reservation station: holds issued instructions, snoops the CDB for
// pending operands and dispatches the oldest ready entry.
module reservation_station #(
   parameter int ENTRIES      = 4,
   parameter int WORD_SIZE    = 32,
   parameter int RB_SIZE      = 8,
   parameter int RB_INDEX     = 4,
   parameter int OPCODE_WIDTH = 6,
   parameter logic [RB_INDEX-1:0] READY = 4'b1111
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   reservation_station_if.slave         bus,
   output logic                         busy,
   output logic [$clog2(ENTRIES+1)-1:0] count
);
   localparam int CW = $clog2(ENTRIES+1);
   localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

   logic [ENTRIES-1:0]      valid_q, valid_d;
   logic [OPCODE_WIDTH-1:0] op_q   [ENTRIES], op_d   [ENTRIES];
   logic [RB_INDEX-1:0]     dest_q [ENTRIES], dest_d [ENTRIES];
   logic [WORD_SIZE-1:0]    vj_q   [ENTRIES], vj_d   [ENTRIES];
   logic [WORD_SIZE-1:0]    vk_q   [ENTRIES], vk_d   [ENTRIES];
   logic [RB_INDEX-1:0]     qj_q   [ENTRIES], qj_d   [ENTRIES];
   logic [RB_INDEX-1:0]     qk_q   [ENTRIES], qk_d   [ENTRIES];
   logic [3:0]              age_q  [ENTRIES], age_d  [ENTRIES];

   logic          sel_found;
   logic [IW-1:0] sel_idx;
   logic [3:0]    sel_age;
   logic [IW-1:0] free_idx;
   logic [CW-1:0] cnt;
   logic          issue_fire, disp_fire;

   // READY is never a lane number, so a READY tag never hits.
   function automatic logic lane_hit(input logic [RB_INDEX-1:0] q,
                                     input logic [RB_SIZE-1:0] v);
      lane_hit = 1'b0;
      for (int l = 0; l < RB_SIZE; l++)
         if (q == RB_INDEX'(l) && v[l]) lane_hit = 1'b1;
   endfunction

   function automatic logic [WORD_SIZE-1:0] lane_data(input logic [RB_INDEX-1:0] q,
                                                       input logic [WORD_SIZE*RB_SIZE-1:0] d);
      lane_data = '0;
      for (int l = 0; l < RB_SIZE; l++)
         if (q == RB_INDEX'(l)) lane_data = d[l*WORD_SIZE +: WORD_SIZE];
   endfunction

   // Oldest ready entry; strict '>' keeps the lowest index on equal ages.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      sel_age   = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (valid_q[i] && qj_q[i] == READY && qk_q[i] == READY &&
             (!sel_found || age_q[i] > sel_age)) begin
            sel_found = 1'b1;
            sel_idx   = IW'(i);
            sel_age   = age_q[i];
         end
      end
   end

   always_comb begin
      free_idx = '0;
      cnt      = '0;
      for (int i = ENTRIES - 1; i >= 0; i--)
         if (!valid_q[i]) free_idx = IW'(i);
      for (int i = 0; i < ENTRIES; i++)
         cnt = cnt + CW'(valid_q[i]);
   end

   assign bus.issue_ready = ~&valid_q;
   assign bus.disp_valid  = sel_found;
   assign bus.disp_op     = sel_found ? op_q[sel_idx]   : '0;
   assign bus.disp_vj     = sel_found ? vj_q[sel_idx]   : '0;
   assign bus.disp_vk     = sel_found ? vk_q[sel_idx]   : '0;
   assign bus.disp_dest   = sel_found ? dest_q[sel_idx] : '0;
   assign count           = cnt;
   assign busy            = (cnt != '0);
   assign issue_fire      = bus.issue_valid & bus.issue_ready;
   assign disp_fire       = sel_found & bus.disp_ready;

   always_comb begin
      valid_d = valid_q;
      op_d    = op_q;
      dest_d  = dest_q;
      vj_d    = vj_q;
      vk_d    = vk_q;
      qj_d    = qj_q;
      qk_d    = qk_q;
      age_d   = age_q;
      for (int i = 0; i < ENTRIES; i++) begin
         if (valid_q[i]) begin
            age_d[i] = (age_q[i] == 4'hF) ? age_q[i] : age_q[i] + 4'd1;
            if (qj_q[i] != READY && lane_hit(qj_q[i], bus.CDB_data_valid)) begin
               vj_d[i] = lane_data(qj_q[i], bus.CDB_data_data);
               qj_d[i] = READY;
            end
            if (qk_q[i] != READY && lane_hit(qk_q[i], bus.CDB_data_valid)) begin
               vk_d[i] = lane_data(qk_q[i], bus.CDB_data_data);
               qk_d[i] = READY;
            end
         end
      end
      if (disp_fire) valid_d[sel_idx] = 1'b0;
      // The allocated slot was invalid this cycle, so it never collides with dispatch.
      if (issue_fire) begin
         valid_d[free_idx] = 1'b1;
         op_d[free_idx]    = bus.issue_op;
         dest_d[free_idx]  = bus.issue_dest;
         age_d[free_idx]   = '0;
         vj_d[free_idx]    = bus.issue_vj;
         qj_d[free_idx]    = bus.issue_qj;
         vk_d[free_idx]    = bus.issue_vk;
         qk_d[free_idx]    = bus.issue_qk;
         if (bus.issue_qj != READY && lane_hit(bus.issue_qj, bus.CDB_data_valid)) begin
            vj_d[free_idx] = lane_data(bus.issue_qj, bus.CDB_data_data);
            qj_d[free_idx] = READY;
         end
         if (bus.issue_qk != READY && lane_hit(bus.issue_qk, bus.CDB_data_valid)) begin
            vk_d[free_idx] = lane_data(bus.issue_qk, bus.CDB_data_data);
            qk_d[free_idx] = READY;
         end
      end
      if (flush) begin
         valid_d = '0;
         for (int i = 0; i < ENTRIES; i++) age_d[i] = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            op_q[i]   <= '0;
            dest_q[i] <= '0;
            vj_q[i]   <= '0;
            vk_q[i]   <= '0;
            qj_q[i]   <= READY;
            qk_q[i]   <= READY;
            age_q[i]  <= '0;
         end
      end else begin
         valid_q <= valid_d;
         op_q    <= op_d;
         dest_q  <= dest_d;
         vj_q    <= vj_d;
         vk_q    <= vk_d;
         qj_q    <= qj_d;
         qk_q    <= qk_d;
         age_q   <= age_d;
      end
   end
endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: an issue-timestamp model checked
// every cycle, plus an expected-dispatch queue of hand-computed records.
module tb_reservation_station;
   localparam int ENT = 4;
   localparam int WS  = 32;
   localparam int RBS = 8;
   localparam int RBI = 4;
   localparam int OPW = 6;
   localparam int W   = OPW + RBI + 2 * WS;
   localparam logic [RBI-1:0] RDY = 4'b1111;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;
   logic busy;
   logic [$clog2(ENT+1)-1:0] count;
   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];

   reservation_station_if #(.WORD_SIZE(WS), .RB_SIZE(RBS), .RB_INDEX(RBI),
                            .OPCODE_WIDTH(OPW)) bus();

   reservation_station #(.ENTRIES(ENT), .WORD_SIZE(WS), .RB_SIZE(RBS), .RB_INDEX(RBI),
                         .OPCODE_WIDTH(OPW), .READY(RDY)) dut (
      .clk(clk), .reset(rst_n), .flush(flush), .bus(bus), .busy(busy), .count(count));

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] rec(input int op, input int dest, input logic [31:0] vj,
                                        input logic [31:0] vk);
      return {OPW'(op), RBI'(dest), vj, vk};
   endfunction

   // behavioural model: pending operands as int tags (-1 = present), age from issue time
   typedef struct {
      bit          v;
      logic [5:0]  op;
      logic [3:0]  dest;
      logic [31:0] vj;
      logic [31:0] vk;
      int          qj;
      int          qk;
      int          born;
   } ment_t;
   ment_t m[ENT];
   int cyc = 0;

   function automatic int m_age(input int i);
      int a;
      a = cyc - m[i].born;
      return (a > 15) ? 15 : a;
   endfunction

   function automatic int m_offer();
      int best;
      best = -1;
      for (int i = 0; i < ENT; i++)
         if (m[i].v && m[i].qj < 0 && m[i].qk < 0 && (best < 0 || m_age(i) > m_age(best)))
            best = i;
      return best;
   endfunction

   function automatic int m_count();
      int n;
      n = 0;
      for (int i = 0; i < ENT; i++) if (m[i].v) n++;
      return n;
   endfunction

   function automatic bit cdb_has(input int tag);
      return tag >= 0 && tag < RBS && bus.CDB_data_valid[tag];
   endfunction

   function automatic logic [31:0] cdb_lane(input int tag);
      return bus.CDB_data_data[tag*WS +: WS];
   endfunction

   always @(posedge clk or negedge rst_n) begin : model_step
      int off;
      int fr;
      int tq;
      if (!rst_n) begin
         for (int i = 0; i < ENT; i++) m[i].v = 1'b0;
         cyc = 0;
      end else if (flush) begin
         for (int i = 0; i < ENT; i++) m[i].v = 1'b0;
         cyc++;
      end else begin
         off = m_offer();
         fr = -1;
         for (int i = ENT - 1; i >= 0; i--) if (!m[i].v) fr = i;
         for (int i = 0; i < ENT; i++) begin
            if (m[i].v && cdb_has(m[i].qj)) begin m[i].vj = cdb_lane(m[i].qj); m[i].qj = -1; end
            if (m[i].v && cdb_has(m[i].qk)) begin m[i].vk = cdb_lane(m[i].qk); m[i].qk = -1; end
         end
         if (off >= 0 && bus.disp_ready) m[off].v = 1'b0;
         cyc++;
         if (bus.issue_valid && fr >= 0) begin
            m[fr].v = 1'b1; m[fr].op = bus.issue_op; m[fr].dest = bus.issue_dest;
            m[fr].born = cyc;
            tq = int'(bus.issue_qj);
            if (bus.issue_qj == RDY) begin m[fr].vj = bus.issue_vj; m[fr].qj = -1; end
            else if (cdb_has(tq)) begin m[fr].vj = cdb_lane(tq); m[fr].qj = -1; end
            else begin m[fr].vj = bus.issue_vj; m[fr].qj = tq; end
            tq = int'(bus.issue_qk);
            if (bus.issue_qk == RDY) begin m[fr].vk = bus.issue_vk; m[fr].qk = -1; end
            else if (cdb_has(tq)) begin m[fr].vk = cdb_lane(tq); m[fr].qk = -1; end
            else begin m[fr].vk = bus.issue_vk; m[fr].qk = tq; end
         end
      end
   end

   // scoreboard / compare, away from the active edge
   always @(negedge clk) begin : compare
      int off;
      logic [W-1:0] e;
      if (rst_n) begin
         off = m_offer();
         check("count", count, m_count());
         check("busy", busy, m_count() != 0);
         check("issue_ready", bus.issue_ready, m_count() < ENT);
         check("disp_valid", bus.disp_valid, off >= 0);
         check("disp_op", bus.disp_op, (off >= 0) ? m[off].op : 6'd0);
         check("disp_dest", bus.disp_dest, (off >= 0) ? m[off].dest : 4'd0);
         check("disp_vj", bus.disp_vj, (off >= 0) ? m[off].vj : 32'd0);
         check("disp_vk", bus.disp_vk, (off >= 0) ? m[off].vk : 32'd0);
         if (bus.disp_valid && bus.disp_ready) begin
            if (exp_q.size() == 0) check("disp_unexpected", 1, 0);
            else begin
               e = exp_q.pop_front();
               check("disp_record", {bus.disp_op, bus.disp_dest, bus.disp_vj, bus.disp_vk}, e);
            end
         end
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic issue(input int op, input int dest, input logic [31:0] vj,
                        input logic [31:0] vk, input logic [3:0] qj, input logic [3:0] qk);
      bus.issue_valid = 1'b1;
      bus.issue_op = OPW'(op);
      bus.issue_dest = RBI'(dest);
      bus.issue_vj = vj;
      bus.issue_vk = vk;
      bus.issue_qj = qj;
      bus.issue_qk = qk;
   endtask

   task automatic idle();
      bus.issue_valid = 1'b0;
   endtask

   task automatic cdb(input int lane, input logic [31:0] data);
      bus.CDB_data_valid[lane] = 1'b1;
      bus.CDB_data_data[lane*WS +: WS] = data;
   endtask

   task automatic cdb_clear();
      bus.CDB_data_valid = '0;
   endtask

   initial begin
      bus.issue_valid = 1'b0; bus.issue_op = '0; bus.issue_dest = '0;
      bus.issue_vj = '0; bus.issue_vk = '0; bus.issue_qj = RDY; bus.issue_qk = RDY;
      bus.CDB_data_data = '0; bus.CDB_data_valid = '0; bus.disp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("rst_issue_ready", bus.issue_ready, 1);
      check("rst_disp_valid", bus.disp_valid, 0);
      check("rst_count", count, 0);
      check("rst_busy", busy, 0);
      rst_n = 1'b1;

      // single ready instruction, dispatched the cycle after issue
      bus.disp_ready = 1'b1;
      exp_q.push_back(rec(3, 2, 5, 7));
      issue(3, 2, 5, 7, RDY, RDY); tick(); idle();
      check("t1_disp_valid", bus.disp_valid, 1);
      check("t1_disp_vj", bus.disp_vj, 5);
      check("t1_disp_vk", bus.disp_vk, 7);
      check("t1_disp_dest", bus.disp_dest, 2);
      tick();
      check("t1_count", count, 0);

      // operand captured from CDB lane 1 two cycles after issue
      exp_q.push_back(rec(1, 3, 32'hAB, 9));
      issue(1, 3, 0, 9, 4'd1, RDY); tick(); idle();
      check("t2_wait0", bus.disp_valid, 0);
      tick();
      cdb(1, 32'hAB);
      check("t2_no_comb", bus.disp_valid, 0);
      tick(); cdb_clear();
      check("t2_disp_valid", bus.disp_valid, 1);
      check("t2_disp_vj", bus.disp_vj, 32'hAB);
      tick();

      // same-cycle bypass from lane 4 at issue
      exp_q.push_back(rec(2, 5, 32'h11, 1));
      issue(2, 5, 0, 1, 4'd4, RDY); cdb(4, 32'h11); tick(); idle(); cdb_clear();
      check("t3_disp_valid", bus.disp_valid, 1);
      check("t3_disp_vj", bus.disp_vj, 32'h11);
      tick();

      // fill all slots, then issue+dispatch while full
      bus.disp_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(rec(4 + i, i, 10 + i, 20 + i));
         issue(4 + i, i, 10 + i, 20 + i, RDY, RDY); tick();
      end
      idle();
      check("t4_full_ready", bus.issue_ready, 0);
      check("t4_full_count", count, 4);
      check("t4_oldest", bus.disp_dest, 0);
      issue(9, 7, 1, 1, RDY, RDY); bus.disp_ready = 1'b1; tick();
      idle(); bus.disp_ready = 1'b0;
      check("t4_count3", count, 3);
      check("t4_ready1", bus.issue_ready, 1);
      bus.disp_ready = 1'b1;
      repeat (3) tick();
      check("t4_drained", count, 0);

      // younger ready entry goes first, older follows once resolved
      bus.disp_ready = 1'b0;
      exp_q.push_back(rec(11, 4, 6, 7));
      exp_q.push_back(rec(10, 1, 32'h33, 2));
      issue(10, 1, 0, 2, 4'd3, RDY); tick();
      issue(11, 4, 6, 7, RDY, RDY); tick(); idle();
      check("t5_b_offer", bus.disp_dest, 4);
      bus.disp_ready = 1'b1; cdb(3, 32'h33); tick(); cdb_clear();
      check("t5_a_offer", bus.disp_dest, 1);
      check("t5_a_vj", bus.disp_vj, 32'h33);
      tick();
      check("t5_count", count, 0);

      // older entry takes over the offer once it becomes ready
      bus.disp_ready = 1'b0;
      exp_q.push_back(rec(12, 5, 32'h66, 3));
      exp_q.push_back(rec(13, 6, 8, 9));
      issue(12, 5, 0, 3, 4'd6, RDY); tick();
      issue(13, 6, 8, 9, RDY, RDY); tick(); idle();
      check("t5_d_offer", bus.disp_dest, 6);
      cdb(6, 32'h66); tick(); cdb_clear();
      check("t5_c_older", bus.disp_dest, 5);
      bus.disp_ready = 1'b1;
      repeat (2) tick();
      check("t5_count2", count, 0);

      // flush with issue in the same cycle, then asynchronous reset mid-stream
      bus.disp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin issue(20 + i, i, i, i, RDY, RDY); tick(); end
      idle();
      check("t6_count3", count, 3);
      flush = 1'b1; issue(30, 7, 1, 1, RDY, RDY); tick();
      flush = 1'b0; idle();
      check("t6_flush_count", count, 0);
      check("t6_flush_ready", bus.issue_ready, 1);
      check("t6_flush_disp", bus.disp_valid, 0);
      for (int i = 0; i < 2; i++) begin issue(40 + i, i, 50 + i, 60 + i, RDY, RDY); tick(); end
      idle();
      check("t6_count2", count, 2);
      @(negedge clk); #1 rst_n = 1'b0;
      #1;
      check("t6_rst_ready", bus.issue_ready, 1);
      check("t6_rst_disp_valid", bus.disp_valid, 0);
      check("t6_rst_disp_vj", bus.disp_vj, 0);
      check("t6_rst_count", count, 0);
      check("t6_rst_busy", busy, 0);
      tick(); rst_n = 1'b1;
      bus.disp_ready = 1'b1;
      exp_q.push_back(rec(1, 1, 32'hDEAD, 32'hBEEF));
      issue(1, 1, 32'hDEAD, 32'hBEEF, RDY, RDY); tick(); idle();
      check("t6_resume", bus.disp_valid, 1);
      tick();
      check("t6_resume_count", count, 0);

      check("exp_q_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
